// File: rtl/calc_result_bcd.sv
// calc_result_bcd: sequential binary-to-BCD converter (double-dabble, one bit
// per clock) sitting between the calculator result and the display driver.
// Acts as a one-entry buffer with valid/ready handshakes on both sides.
module calc_result_bcd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [SW-1:0]    scratch_reg;
  logic [CW-1:0]    count_reg;
  logic [SW-1:0]    bcd_reg;

  logic [SW-1:0]    corrected;
  logic [SW-1:0]    scratch_next;
  logic [WIDTH-1:0] bin_next;

  // Add-3 correction on every digit in parallel, using pre-shift values, so
  // that a digit >= 5 carries correctly into the next digit after doubling.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = scratch_reg[gi*4 +: 4];
      assign corrected[gi*4 +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
  endgenerate

  // One-bit left shift of {scratch, binary}: binary MSB feeds scratch LSB.
  assign scratch_next = {corrected[SW-2:0], bin_reg[WIDTH-1]};
  assign bin_next     = {bin_reg[WIDTH-2:0], 1'b0};

  // Control FSM and datapath registers; reset discards any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      count_reg   <= '0;
      bcd_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg     <= in_data;
            scratch_reg <= '0;
            count_reg   <= CW'(WIDTH);
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          bin_reg     <= bin_next;
          count_reg   <= count_reg - CW'(1);
          // Counter at 1 means this edge performs the final shift.
          if (count_reg == CW'(1)) begin
            bcd_reg   <= scratch_next;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == SHIFT);
  assign bcd       = bcd_reg;

endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed testbench for calc_result_bcd: conversions, latency, backpressure,
// ignored input, mid-conversion reset and back-to-back streaming.
module tb_calc_result_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] bcd;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  calc_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for out_valid; returns edges elapsed and busy cycles seen.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!out_valid && edges < 30) begin
      if (busy) busy_cnt++;
      tick();
      edges++;
    end
  endtask

  // Full conversion with out_ready high; called at a negedge in IDLE.
  task automatic do_conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int edges, bc;
    in_valid = 1'b1;
    in_data  = v;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();                       // acceptance edge E0
    in_valid = 1'b0;
    in_data  = 8'd0;
    wait_done(edges, bc);
    chk({tag, "_latency"}, edges + 1, 9);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_bcd"}, bcd, exp);
    tick();                       // handshake edge
    chk({tag, "_idle_after"}, {in_ready, out_valid}, 2'b10);
    chk({tag, "_bcd_hold"}, bcd, exp);
    $display("conv %0d -> bcd %03h latency %0d busy %0d", v, bcd, edges + 1, bc);
  endtask

  initial begin
    int edges, bc, n;
    int acc [3];
    logic [7:0]  bb_in  [3];
    logic [11:0] bb_exp [3];

    // Reset values: async reset with no clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcd, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset released at cycle %0d", cyc);

    // Basic conversions with out_ready tied high.
    out_ready = 1'b1;
    do_conv(8'd0,   12'h000, "c0");
    do_conv(8'd12,  12'h012, "c12");
    do_conv(8'd27,  12'h027, "c27");
    do_conv(8'd6,   12'h006, "c6");
    do_conv(8'd255, 12'h255, "c255");

    // Backpressure: convert 99, hold out_ready low for 5 cycles.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd99;
    tick();
    in_valid = 1'b0;
    wait_done(edges, bc);
    chk("bp_latency", edges + 1, 9);
    chk("bp_bcd", bcd, 12'h099);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_bcd", bcd, 12'h099);
      chk("bp_stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", {in_ready, out_valid}, 2'b10);
    chk("bp_bcd_after", bcd, 12'h099);
    $display("backpressure 99 -> bcd %03h", bcd);

    // Ignored input: accept 45, then hold 200 on the input during SHIFT/DONE.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd45;
    tick();
    in_data  = 8'd200;
    wait_done(edges, bc);
    chk("ign_latency", edges + 1, 9);
    chk("ign_bcd", bcd, 12'h045);
    tick();
    tick();
    chk("ign_done_hold", {out_valid, in_ready, busy}, 3'b100);
    chk("ign_bcd_hold", bcd, 12'h045);
    out_ready = 1'b1;
    tick();                       // handshake edge
    chk("ign_idle", in_ready, 1);
    tick();                       // 200 accepted here
    in_valid = 1'b0;
    chk("ign_second_busy", busy, 1);
    wait_done(edges, bc);
    chk("ign_second_bcd", bcd, 12'h200);
    tick();
    $display("ignored-input 45 then 200 -> bcd %03h", bcd);

    // Reset mid-conversion: accept 128, reset after the 4th shift edge.
    in_valid = 1'b1;
    in_data  = 8'd128;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_bcd", bcd, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mr_stays_idle", {in_ready, busy, out_valid}, 3'b100);
    $display("mid-conversion reset -> bcd %03h", bcd);
    do_conv(8'd128, 12'h128, "mr128");

    // Back-to-back: in_valid and out_ready held high.
    bb_in[0] = 8'd1;  bb_exp[0] = 12'h001;
    bb_in[1] = 8'd2;  bb_exp[1] = 12'h002;
    bb_in[2] = 8'd3;  bb_exp[2] = 12'h003;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = bb_in[i];
      n = 0;
      while (!in_ready && n < 30) begin
        tick();
        n++;
      end
      chk("bb_in_ready", in_ready, 1);
      acc[i] = cyc;
      tick();
      wait_done(edges, bc);
      chk("bb_bcd", bcd, bb_exp[i]);
      $display("stream %0d -> bcd %03h accepted at cycle %0d", bb_in[i], bcd, acc[i]);
    end
    in_valid = 1'b0;
    chk("bb_gap01", acc[1] - acc[0], 10);
    chk("bb_gap12", acc[2] - acc[1], 10);
    tick();
    chk("bb_final_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
